// File: rtl/mem_read_ctrl_if.sv
// Bus bundle between the pipeline memory stage, the read controller and the data memory.
// The master side is the pipeline/memory environment; the slave side is mem_read_ctrl.
interface mem_read_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 16
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_done;
  logic [WIDTH-1:0]  mem_rd_data;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              rd_err;

  modport master (
    output rd_req, rd_addr, mem_done, mem_rd_data,
    input  busy, mem_en, mem_addr, rd_data, rd_valid, rd_err
  );

  modport slave (
    input  rd_req, rd_addr, mem_done, mem_rd_data,
    output busy, mem_en, mem_addr, rd_data, rd_valid, rd_err
  );
endinterface

// File: rtl/mem_read_ctrl.sv
// Read-side controller: issues one memory read per request, waits for done, captures data or times out.
// Optional macro ALIGN_CHK_EN rejects odd (misaligned) addresses with an rd_err pulse instead of issuing.
module mem_read_ctrl #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input logic            clk,
  input logic            rst,
  mem_read_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             misaligned;

  if (TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_timeout_range
    $error("mem_read_ctrl: TIMEOUT must lie in 1..2**CNT_W-1");
  end

`ifdef ALIGN_CHK_EN
  assign misaligned = bus.rd_addr[0];
`else
  assign misaligned = 1'b0;
`endif

  // Every output is a register; pulse outputs default low and are raised only on the
  // transition that produces them, so valid and err can never coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      bus.busy     <= 1'b0;
      bus.mem_en   <= 1'b0;
      bus.mem_addr <= {ADDR_W{1'b0}};
      bus.rd_data  <= {WIDTH{1'b0}};
      bus.rd_valid <= 1'b0;
      bus.rd_err   <= 1'b0;
    end else begin
      bus.mem_en   <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rd_req) begin
            if (misaligned) begin
              bus.rd_err <= 1'b1;
            end else begin
              bus.mem_addr <= bus.rd_addr;
              bus.mem_en   <= 1'b1;
              bus.busy     <= 1'b1;
              state        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        // The counter stops once it reaches TIMEOUT because that cycle always leaves WAIT.
        WAIT: begin
          if (bus.mem_done) begin
            bus.rd_data  <= bus.mem_rd_data;
            bus.rd_valid <= 1'b1;
            state        <= DONE;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            bus.rd_err <= 1'b1;
            bus.busy   <= 1'b0;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_read_ctrl.sv
// Bench for mem_read_ctrl: directed vector table, multi-cycle corner sequences, then random traffic
// against a request-age reference model. Expectations follow ALIGN_CHK_EN when it is defined.
`timescale 1ns/1ps
module tb_mem_read_ctrl;
  localparam int WIDTH   = 16;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  mem_read_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  mem_read_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [15:0] addr;
    logic        done;
    logic [15:0] din;
    logic        busy;
    logic        en;
    logic [15:0] maddr;
    logic [15:0] data;
    logic        valid;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  // Reference model: tracks the age of the accepted request in cycles (1 = issue cycle,
  // 2..TIMEOUT+2 = waiting window) rather than any controller state.
  bit          m_busy;
  int          m_age;
  bit          m_got;
  logic [15:0] m_addr;
  logic [15:0] m_data;
  bit          m_valid;
  bit          m_err;

  task automatic applyStimulus(input logic req, input logic [ADDR_W-1:0] addr,
                               input logic done, input logic [WIDTH-1:0] din);
    bus.rd_req      = req;
    bus.rd_addr     = addr;
    bus.mem_done    = done;
    bus.mem_rd_data = din;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] outs();
    return {bus.busy, bus.mem_en, bus.mem_addr, bus.rd_data, bus.rd_valid, bus.rd_err};
  endfunction

  function automatic logic [35:0] modelOuts();
    return {m_busy, (m_busy && m_age == 1), m_addr, m_data, m_valid, m_err};
  endfunction

  task automatic modelReset();
    m_busy = 0; m_age = 0; m_got = 0; m_addr = '0; m_data = '0; m_valid = 0; m_err = 0;
  endtask

  // Advance the model across one clock edge using the inputs that were present before it.
  task automatic modelStep(input logic req, input logic [15:0] addr, input logic done,
                           input logic [15:0] din);
    bit nv;
    bit ne;
    nv = 0;
    ne = 0;
    if (!m_busy) begin
      if (req) begin
`ifdef ALIGN_CHK_EN
        if (addr[0]) ne = 1;
        else begin m_busy = 1; m_age = 1; m_got = 0; m_addr = addr; end
`else
        m_busy = 1; m_age = 1; m_got = 0; m_addr = addr;
`endif
      end
    end else if (m_got) begin
      m_busy = 0;
    end else if (m_age >= 2 && done) begin
      m_got = 1; m_data = din; nv = 1; m_age++;
    end else if (m_age - 2 == TIMEOUT) begin
      m_busy = 0; ne = 1;
    end else begin
      m_age++;
    end
    m_valid = nv;
    m_err   = ne;
  endtask

  function automatic vec_t mkVec(logic req, logic [15:0] addr, logic done, logic [15:0] din,
                                 logic busy, logic en, logic [15:0] maddr, logic [15:0] data,
                                 logic valid, logic err);
    vec_t v;
    v.req = req; v.addr = addr; v.done = done; v.din = din;
    v.busy = busy; v.en = en; v.maddr = maddr; v.data = data; v.valid = valid; v.err = err;
    return v;
  endfunction

  initial begin
    int          en_cnt;
    int          valid_cnt;
    int          err_at;
    int          p_done;
    logic        r_req;
    logic [15:0] r_addr;
    logic        r_done;
    logic [15:0] r_din;

    // Each row: inputs held for one cycle, outputs expected just after the following edge.
    // Fastest read: valid lands in the 4th cycle counting the request cycle; done during
    // ISSUE, DONE and IDLE must be ignored.
    vecs.push_back(mkVec(1, 16'h0100, 0, 16'h0000, 1, 1, 16'h0100, 16'h0000, 0, 0));
    vecs.push_back(mkVec(0, 16'h0000, 1, 16'hDEAD, 1, 0, 16'h0100, 16'h0000, 0, 0));
    vecs.push_back(mkVec(0, 16'h0000, 1, 16'h1234, 1, 0, 16'h0100, 16'h1234, 1, 0));
    vecs.push_back(mkVec(0, 16'h0000, 1, 16'hFFFF, 0, 0, 16'h0100, 16'h1234, 0, 0));
    vecs.push_back(mkVec(0, 16'h0000, 1, 16'hEEEE, 0, 0, 16'h0100, 16'h1234, 0, 0));
    // Basic read: done arrives three cycles after the mem_en cycle.
    vecs.push_back(mkVec(1, 16'h0042, 0, 16'h0000, 1, 1, 16'h0042, 16'h1234, 0, 0));
    vecs.push_back(mkVec(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0042, 16'h1234, 0, 0));
    vecs.push_back(mkVec(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0042, 16'h1234, 0, 0));
    vecs.push_back(mkVec(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0042, 16'h1234, 0, 0));
    vecs.push_back(mkVec(0, 16'h0000, 1, 16'hBEEF, 1, 0, 16'h0042, 16'hBEEF, 1, 0));
    vecs.push_back(mkVec(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0042, 16'hBEEF, 0, 0));

    applyStimulus(0, '0, 0, '0);
    #2 rst = 1'b0;
    tick();
    tick();
    checkOutput("reset_values", outs(), 36'h0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].req, vecs[i].addr, vecs[i].done, vecs[i].din);
      tick();
      checkOutput($sformatf("vec%0d", i), outs(),
                  {vecs[i].busy, vecs[i].en, vecs[i].maddr, vecs[i].data, vecs[i].valid, vecs[i].err});
    end

    // Timeout: no done ever; error pulse TIMEOUT+3 cycles after the request, data kept.
    applyStimulus(1, 16'h0200, 0, '0);
    tick();
    applyStimulus(0, '0, 0, '0);
    en_cnt = 0; valid_cnt = 0; err_at = -1;
    for (int c = 1; c <= 40 && err_at < 0; c++) begin
      if (bus.mem_en) en_cnt++;
      if (bus.rd_valid) valid_cnt++;
      if (bus.rd_err) begin
        err_at = c;
        checkOutput("timeout_data_busy", {bus.busy, bus.rd_data}, {1'b0, 16'hBEEF});
      end else begin
        tick();
      end
    end
    checkOutput("timeout_latency", err_at, TIMEOUT + 3);
    checkOutput("timeout_en_count", en_cnt, 1);
    checkOutput("timeout_no_valid", valid_cnt, 0);
    tick();
    checkOutput("timeout_err_pulse", {bus.busy, bus.rd_err}, 2'b00);

    // Overlap: rd_req held high while busy, new address mid-WAIT must wait for IDLE.
    applyStimulus(1, 16'h0080, 0, '0);
    tick();
    checkOutput("ovl_first_issue", {bus.mem_en, bus.mem_addr}, {1'b1, 16'h0080});
    en_cnt = 0;
    tick();
    if (bus.mem_en) en_cnt++;
    applyStimulus(1, 16'h0010, 0, '0);
    tick();
    if (bus.mem_en) en_cnt++;
    tick();
    if (bus.mem_en) en_cnt++;
    applyStimulus(1, 16'h0010, 1, 16'h5555);
    tick();
    checkOutput("ovl_valid", {bus.rd_valid, bus.rd_data, bus.mem_addr}, {1'b1, 16'h5555, 16'h0080});
    checkOutput("ovl_extra_en", en_cnt, 0);
    applyStimulus(1, 16'h0010, 0, '0);
    tick();
    checkOutput("ovl_idle_gap", {bus.busy, bus.mem_en}, 2'b00);
    tick();
    checkOutput("ovl_second_issue", {bus.busy, bus.mem_en, bus.mem_addr}, {2'b11, 16'h0010});
    applyStimulus(0, '0, 0, '0);
    tick();
    applyStimulus(0, '0, 1, 16'h6666);
    tick();
    applyStimulus(0, '0, 0, '0);
    tick();
    checkOutput("ovl_second_data", {bus.busy, bus.rd_data}, {1'b0, 16'h6666});

    // Odd address: rejected with an error pulse when the check is built in, issued otherwise.
    applyStimulus(1, 16'h0043, 0, '0);
    tick();
    applyStimulus(0, '0, 0, '0);
`ifdef ALIGN_CHK_EN
    checkOutput("align_reject", {bus.busy, bus.mem_en, bus.mem_addr, bus.rd_err},
                {2'b00, 16'h0010, 1'b1});
    tick();
    checkOutput("align_err_pulse", {bus.busy, bus.mem_en, bus.rd_err}, 3'b000);
`else
    checkOutput("align_issue", {bus.busy, bus.mem_en, bus.mem_addr, bus.rd_err},
                {2'b11, 16'h0043, 1'b0});
    tick();
    applyStimulus(0, '0, 1, 16'h7777);
    tick();
    checkOutput("align_read", {bus.rd_valid, bus.rd_data}, {1'b1, 16'h7777});
    applyStimulus(0, '0, 0, '0);
    tick();
`endif

    // Asynchronous reset in the middle of WAIT, then a late done that must be ignored.
    applyStimulus(1, 16'h0300, 0, '0);
    tick();
    applyStimulus(0, '0, 0, '0);
    tick();
    tick();
    #3 rst = 1'b0;
    #1;
    checkOutput("reset_async", outs(), 36'h0);
    applyStimulus(0, '0, 1, 16'hABCD);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("reset_late_done", outs(), 36'h0);
    applyStimulus(0, '0, 0, '0);
    tick();

    // Random traffic against the model; done probability changes every 100 cycles so that
    // long silent stretches produce timeouts.
    rst = 1'b0;
    modelReset();
    tick();
    rst = 1'b1;
    p_done = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(0, 2))
          0:       p_done = 0;
          1:       p_done = 5;
          default: p_done = 35;
        endcase
      end
      r_req  = ($urandom_range(0, 99) < 30);
      r_addr = 16'($urandom);
      r_done = ($urandom_range(0, 99) < p_done);
      r_din  = 16'($urandom);
      applyStimulus(r_req, r_addr, r_done, r_din);
      tick();
      modelStep(r_req, r_addr, r_done, r_din);
      checkOutput($sformatf("random_cycle%0d", i), outs(), modelOuts());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
